logisim_tick_clock: RTL and testbench

LOGISIM_TICK_CLOCK -- requirements
Module: logisim_tick_clock

---
 rtl/logisim_clock_pkg.sv | 18 +
 rtl/logisim_tick_watchdog.sv | 34 +++
 rtl/logisim_tick_clock.sv | 157 +++++++++++++++
 tb/tb_logisim_tick_clock.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/logisim_clock_pkg.sv
// Shared state encoding and helpers for the tick-driven simulated-circuit clock.
package logisim_clock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RUN_HIGH  = 3'd1,
        ST_RUN_LOW   = 3'd2,
        ST_STEP_HIGH = 3'd3,
        ST_STEP_LOW  = 3'd4,
        ST_STEP_DONE = 3'd5
    } clk_state_e;

    // States in which a missing tick stream stalls the simulated clock.
    function automatic logic wd_active(input clk_state_e s);
        return (s != ST_IDLE) && (s != ST_STEP_DONE);
    endfunction

endpackage

// File: rtl/logisim_tick_watchdog.sv
// Sticky tick-loss detector: flags WatchdogCycles consecutive tick-less active cycles.
module logisim_tick_watchdog #(
    parameter int WatchdogCycles = 1024
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_active,
    input  logic i_tick,
    output logic o_timeout
);

    localparam int CW = $clog2(WatchdogCycles + 1);
    localparam logic [CW-1:0] LIMIT   = CW'(WatchdogCycles - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [CW-1:0] r_gap_cnt;
    logic          r_timeout;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_gap_cnt <= '0;
            r_timeout <= 1'b0;
        end else if (!i_active || i_tick) begin
            r_gap_cnt <= '0;
        end else if (r_gap_cnt == LIMIT) begin
            r_timeout <= 1'b1;
        end else begin
            r_gap_cnt <= r_gap_cnt + CNT_ONE;
        end
    end

    assign o_timeout = r_timeout;

endmodule

// File: rtl/logisim_tick_clock.sv
// Tick-driven simulated-circuit clock with free-run and four-phase single-step modes.
// Optional tick-loss watchdog is built only when TICK_WATCHDOG_EN is defined.
module logisim_tick_clock
    import logisim_clock_pkg::*;
#(
    parameter int NrOfBits       = 8,
    parameter int HighTicks      = 1,
    parameter int LowTicks       = 1,
    parameter int WatchdogCycles = 1024
) (
    input  logic FPGAClock,
    input  logic FPGAReset_n,
    input  logic FPGATick,
    input  logic Run,
    input  logic StepReq,
    output logic StepAck,
    output logic ClockBus,
    output logic ClockTick,
    output logic TickTimeout
);

    localparam logic [NrOfBits-1:0] HIGH_LOAD = NrOfBits'(HighTicks - 1);
    localparam logic [NrOfBits-1:0] LOW_LOAD  = NrOfBits'(LowTicks - 1);
    localparam logic [NrOfBits-1:0] CNT_ONE   = NrOfBits'(1);

    generate
        if (NrOfBits < 1 || HighTicks < 1 || LowTicks < 1 || WatchdogCycles < 1) begin : g_bad_param
            $error("logisim_tick_clock: all parameters must be >= 1");
        end
    endgenerate

    clk_state_e          r_state;
    logic [NrOfBits-1:0] r_cnt;
    logic                r_clock_bus;
    logic                r_clock_tick;
    logic                r_step_ack;
    logic                w_cnt_zero;

    assign w_cnt_zero = (r_cnt == '0);

    // Every entry into a high state comes from a low state, so the edge pulse
    // is raised together with the bus and cleared by default the next cycle.
    always_ff @(posedge FPGAClock or negedge FPGAReset_n) begin
        if (!FPGAReset_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_clock_bus  <= 1'b0;
            r_clock_tick <= 1'b0;
            r_step_ack   <= 1'b0;
        end else begin
            r_clock_tick <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (FPGATick) begin
                        if (Run) begin
                            r_state      <= ST_RUN_HIGH;
                            r_cnt        <= HIGH_LOAD;
                            r_clock_bus  <= 1'b1;
                            r_clock_tick <= 1'b1;
                        end else if (StepReq && !r_step_ack) begin
                            r_state      <= ST_STEP_HIGH;
                            r_cnt        <= HIGH_LOAD;
                            r_clock_bus  <= 1'b1;
                            r_clock_tick <= 1'b1;
                        end
                    end
                end
                ST_RUN_HIGH: begin
                    if (FPGATick) begin
                        if (w_cnt_zero) begin
                            r_state     <= ST_RUN_LOW;
                            r_cnt       <= LOW_LOAD;
                            r_clock_bus <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt - CNT_ONE;
                        end
                    end
                end
                ST_RUN_LOW: begin
                    if (FPGATick) begin
                        if (w_cnt_zero) begin
                            if (Run) begin
                                r_state      <= ST_RUN_HIGH;
                                r_cnt        <= HIGH_LOAD;
                                r_clock_bus  <= 1'b1;
                                r_clock_tick <= 1'b1;
                            end else begin
                                r_state <= ST_IDLE;
                                r_cnt   <= '0;
                            end
                        end else begin
                            r_cnt <= r_cnt - CNT_ONE;
                        end
                    end
                end
                ST_STEP_HIGH: begin
                    if (FPGATick) begin
                        if (w_cnt_zero) begin
                            r_state     <= ST_STEP_LOW;
                            r_cnt       <= LOW_LOAD;
                            r_clock_bus <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt - CNT_ONE;
                        end
                    end
                end
                ST_STEP_LOW: begin
                    if (FPGATick) begin
                        if (w_cnt_zero) begin
                            r_state    <= ST_STEP_DONE;
                            r_cnt      <= '0;
                            r_step_ack <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - CNT_ONE;
                        end
                    end
                end
                ST_STEP_DONE: begin
                    // Handshake release is not tick-qualified.
                    if (!StepReq) begin
                        r_state    <= ST_IDLE;
                        r_step_ack <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cnt       <= '0;
                    r_clock_bus <= 1'b0;
                    r_step_ack  <= 1'b0;
                end
            endcase
        end
    end

    assign ClockBus  = r_clock_bus;
    assign ClockTick = r_clock_tick;
    assign StepAck   = r_step_ack;

`ifdef TICK_WATCHDOG_EN
    logic w_wd_active;

    assign w_wd_active = wd_active(r_state);

    logisim_tick_watchdog #(
        .WatchdogCycles(WatchdogCycles)
    ) u_watchdog (
        .i_clk    (FPGAClock),
        .i_rst_n  (FPGAReset_n),
        .i_active (w_wd_active),
        .i_tick   (FPGATick),
        .o_timeout(TickTimeout)
    );
`else
    assign TickTimeout = 1'b0;
`endif

endmodule

// File: tb/tb_logisim_tick_clock.sv
// Directed bench for logisim_tick_clock: free-run, step handshake, reset and watchdog.
module tb_logisim_tick_clock;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic tick  = 1'b0;
    logic run   = 1'b0;
    logic sreq  = 1'b0;

    logic a_ack, a_bus, a_ct, a_to;
    logic b_ack, b_bus, b_ct, b_to;

    int n_cmp = 0;
    int n_bad = 0;
    int tick_sum;

    always #5 clk = ~clk;

    // A: asymmetric phases; B: single-tick phases.
    logisim_tick_clock #(.NrOfBits(8), .HighTicks(2), .LowTicks(3), .WatchdogCycles(16)) dut_a (
        .FPGAClock(clk), .FPGAReset_n(rst_n), .FPGATick(tick), .Run(run), .StepReq(sreq),
        .StepAck(a_ack), .ClockBus(a_bus), .ClockTick(a_ct), .TickTimeout(a_to)
    );

    logisim_tick_clock #(.NrOfBits(8), .HighTicks(1), .LowTicks(1), .WatchdogCycles(16)) dut_b (
        .FPGAClock(clk), .FPGAReset_n(rst_n), .FPGATick(tick), .Run(run), .StepReq(sreq),
        .StepAck(b_ack), .ClockBus(b_bus), .ClockTick(b_ct), .TickTimeout(b_to)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick  = 1'b0;
        run   = 1'b0;
        sreq  = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_a_outs", {a_bus, a_ct, a_ack, a_to}, 4'b0000);
        chk("rst_b_outs", {b_bus, b_ct, b_ack, b_to}, 4'b0000);

        // H=2 L=3 free-run: 1,1,0,0,0 repeating, one edge pulse per period
        do_reset();
        tick = 1'b1;
        run  = 1'b1;
        tick_sum = 0;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            chk($sformatf("h2l3_bus[%0d]", k), a_bus, ((k - 1) % 5) < 2);
            chk($sformatf("h2l3_ct[%0d]", k), a_ct, ((k - 1) % 5) == 0);
            tick_sum += a_ct;
        end
        chk("h2l3_ct_total", tick_sum, 2);

        // H=L=1 with tick tied high: toggle every cycle
        do_reset();
        tick = 1'b1;
        run  = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            chk($sformatf("toggle_bus[%0d]", k), b_bus, k % 2);
            chk($sformatf("toggle_ct[%0d]", k), b_ct, k % 2);
        end

        // Tick every 4th cycle: period of 8 cycles
        do_reset();
        run = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick = ((k - 1) % 4) == 0;
            cyc();
            chk($sformatf("div4_bus[%0d]", k), b_bus, (((k - 1) / 4) % 2) == 0);
            chk($sformatf("div4_ct[%0d]", k), b_ct, (k == 1) || (k == 9));
        end

        // Run dropped in second high tick: high completes, 3 low, then idle
        do_reset();
        tick = 1'b1;
        run  = 1'b1;
        cyc();
        chk("drop_bus[1]", a_bus, 1);
        run = 1'b0;
        for (int k = 2; k <= 9; k++) begin
            cyc();
            chk($sformatf("drop_bus[%0d]", k), a_bus, k <= 2);
            chk($sformatf("drop_ct[%0d]", k), a_ct, 0);
        end

        // Single step with Run=0
        do_reset();
        tick = 1'b1;
        sreq = 1'b1;
        tick_sum = 0;
        for (int k = 1; k <= 5; k++) begin
            cyc();
            chk($sformatf("step_bus[%0d]", k), b_bus, k == 1);
            chk($sformatf("step_ack[%0d]", k), b_ack, k >= 3);
            tick_sum += b_ct;
        end
        sreq = 1'b0;
        tick = 1'b0;
        cyc();
        chk("step_ack_release", b_ack, 0);
        tick = 1'b1;
        for (int k = 7; k <= 8; k++) begin
            cyc();
            chk($sformatf("step_idle[%0d]", k), {b_bus, b_ack}, 2'b00);
            tick_sum += b_ct;
        end
        chk("step_ct_total", tick_sum, 1);

        // Run and StepReq together: run first, step stays pending
        do_reset();
        tick = 1'b1;
        run  = 1'b1;
        sreq = 1'b1;
        cyc();
        chk("prio_bus[1]", b_bus, 1);
        chk("prio_ack[1]", b_ack, 0);
        run = 1'b0;
        for (int k = 2; k <= 6; k++) begin
            cyc();
            chk($sformatf("prio_bus[%0d]", k), b_bus, k == 4);
            chk($sformatf("prio_ct[%0d]", k), b_ct, k == 4);
            chk($sformatf("prio_ack[%0d]", k), b_ack, k == 6);
        end
        sreq = 1'b0;
        cyc();
        chk("prio_ack_release", b_ack, 0);

        // Reset during STEP_HIGH: outputs clear immediately, no ack
        do_reset();
        tick = 1'b1;
        sreq = 1'b1;
        cyc();
        chk("rstmid_bus_pre", b_bus, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rstmid_outs", {b_bus, b_ct, b_ack, b_to}, 4'b0000);
        for (int k = 1; k <= 3; k++) begin
            cyc();
            chk($sformatf("rstmid_hold[%0d]", k), {b_bus, b_ct, b_ack}, 3'b000);
        end
        sreq = 1'b0;
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            chk($sformatf("rstmid_after[%0d]", k), {b_bus, b_ct, b_ack}, 3'b000);
        end

        // Tick loss while running
        do_reset();
        tick = 1'b1;
        run  = 1'b1;
        cyc();
        tick = 1'b0;
        for (int k = 1; k <= 15; k++) cyc();
        chk("wd_cycle15", b_to, 0);
        cyc();
`ifdef TICK_WATCHDOG_EN
        chk("wd_cycle16", b_to, 1);
`else
        chk("wd_cycle16", b_to, 0);
`endif
        tick = 1'b1;
        run  = 1'b0;
        for (int k = 1; k <= 4; k++) cyc();
`ifdef TICK_WATCHDOG_EN
        chk("wd_sticky", b_to, 1);
`else
        chk("wd_sticky", b_to, 0);
`endif
        rst_n = 1'b0;
        #1;
        chk("wd_reset_clear", b_to, 0);
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
